// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Streams sequential 16-bit instruction words from the instruction-memory
// port into the instruction buffer (IB). Each pushed entry is tagged with its
// word address: {addr[15:0], instr[15:0]}.
//
// Two address registers run independently:
//   pc_q        - next address to request from memory
//   expect_pc_q - next address the IB is waiting for
// Memory responses may come back with any latency and in any order. Only a
// response tagged with expect_pc_q is pushed; every other response is dropped.
// A matching response that cannot be pushed because the IB is full rewinds
// pc_q to expect_pc_q. The word is then fetched again, which is safe because
// instruction memory is read-only.
//
// Optional feature (compile-time macro FETCH_HALT_EN):
//   When it is defined, pushing a word whose opcode nibble is 4'hF stops any
//   further requests. A branch or a reset restarts fetching. When it is not
//   defined, fetch streams indefinitely.

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction buffer push side
    output logic        ib_push,
    output logic [31:0] ib_push_data,
    input  logic        ib_full,

    // Instruction memory request/response
    output logic [15:0] imem_raddr,
    output logic        imem_re,
    input  logic [15:0] imem_raddr_out,
    input  logic [15:0] imem_data_out,
    input  logic        imem_ready,

    // Redirect from the branch unit
    input  logic        branch_taken,
    input  logic [15:0] branch_target
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] expect_pc_q;
    logic [15:0] expect_pc_d;
    logic        halted_q;

    // Response classification
    logic        resp_match;   // response carries the address we wait for
    logic        resp_drop;    // matching response, but the IB cannot take it

`ifdef FETCH_HALT_EN
    logic        halted_d;
    logic        halt_word;    // the word being pushed is a halt instruction
`endif

    // ------------------------------------------------------------------
    // Request side: always ask for pc. Requests stop while the IB is
    // full, while fetch is halted, or while reset is held. rst_n gates
    // the strobe directly so that it drops as soon as reset is asserted.
    // ------------------------------------------------------------------
    assign imem_raddr = pc_q;
    assign imem_re    = rst_n & ~ib_full & ~halted_q;

    // ------------------------------------------------------------------
    // Response side: push only the in-order word. A redirect in the same
    // cycle makes that word stale. rst_n also gates the push so that no
    // late response reaches the IB while reset is held.
    // ------------------------------------------------------------------
    // Classify the returning response against the address we wait for
    always_comb begin
        resp_match = imem_ready & (imem_raddr_out == expect_pc_q);
        resp_drop  = resp_match & ib_full;
    end

    assign ib_push      = rst_n & resp_match & ~ib_full & ~branch_taken;
    assign ib_push_data = {imem_raddr_out, imem_data_out};

    // ------------------------------------------------------------------
    // Next-state for the two address registers. The three cases are
    // checked in priority order:
    //   1. redirect: both pointers jump to the branch target
    //   2. drop:     rewind pc so the dropped word is fetched again
    //   3. stream:   advance pc on a request and expect_pc on a push
    //                (both may advance in the same cycle)
    // Addresses wrap modulo 2^16 through the 16-bit adders.
    // ------------------------------------------------------------------
    // Compute the next request and expected-response addresses
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so that no path leaves it unassigned and no latch is inferred.
        pc_d        = pc_q;
        expect_pc_d = expect_pc_q;

        if (branch_taken) begin
            pc_d        = branch_target;
            expect_pc_d = branch_target;
        end else if (resp_drop) begin
            pc_d        = expect_pc_q;
        end else begin
            if (imem_re) begin
                pc_d = pc_q + 16'd1;
            end
            if (ib_push) begin
                expect_pc_d = expect_pc_q + 16'd1;
            end
        end
    end

    // Register the request and expected-response addresses
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge, whatever the block order.
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            expect_pc_q <= RESET_PC;
        end else begin
            pc_q        <= pc_d;
            expect_pc_q <= expect_pc_d;
        end
    end

`ifdef FETCH_HALT_EN
    // ------------------------------------------------------------------
    // Halt tracking. Halt takes effect from the cycle after the halt
    // word is pushed. Responses already in flight are still pushed if
    // they match, because only new requests are blocked.
    // ------------------------------------------------------------------
    assign halt_word = (imem_data_out[15:12] == 4'hF);

    // Set halted on a pushed halt word and clear it on a redirect
    always_comb begin
        halted_d = halted_q;
        if (branch_taken) begin
            halted_d = 1'b0;
        end else if (ib_push && halt_word) begin
            halted_d = 1'b1;
        end
    end

    // Register the halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    // Without the halt feature, fetch never stops by itself
    assign halted_q = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
//
// The memory model accepts every request and returns it after a latency drawn
// from [lat_min, lat_max]. When several responses are due, one is chosen at
// random, so responses can come back out of order. The reference model only
// knows what the IB should see: a gap-free run of addresses that starts at
// RESET_PC or at the latest branch target, each with the correct memory word.
// Set FETCH_HALT_EN to also cover the halt feature.

`timescale 1ns/1ps

module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ib_push;
    logic [31:0] ib_push_data;
    logic        ib_full;
    logic [15:0] imem_raddr;
    logic        imem_re;
    logic [15:0] imem_raddr_out;
    logic [15:0] imem_data_out;
    logic        imem_ready;
    logic        branch_taken;
    logic [15:0] branch_target;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ib_push        (ib_push),
        .ib_push_data   (ib_push_data),
        .ib_full        (ib_full),
        .imem_raddr     (imem_raddr),
        .imem_re        (imem_re),
        .imem_raddr_out (imem_raddr_out),
        .imem_data_out  (imem_data_out),
        .imem_ready     (imem_ready),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        inflight[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          p_full  = 0;
    int          p_br    = 0;
    bit          force_full = 1'b0;
    bit          force_br   = 1'b0;
    logic [15:0] force_tgt  = 16'h0000;
    bit          halt_word_en = 1'b0;

    // Reference model state
    logic [15:0] ref_expect;
    bit          ref_halted;
    int          n_push = 0;

    // Outputs observed in the most recent cycle
    bit          last_push;
    bit          last_re;
    logic [15:0] last_raddr;
    logic [15:0] last_addr;
    logic [15:0] last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Contents of instruction memory. The top nibble is never 4'hF unless
    // the halt word at address 3 is switched on.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_word_en && a == 16'h0003) return 16'hF000;
        return {1'b0, a[14:0]} ^ 16'h2C35;
    endfunction

    // Branch targets are biased toward the wrap point
    function automatic logic [15:0] pick_target();
        if ($urandom_range(0, 3) == 0) return 16'hFFFC + 16'($urandom_range(0, 5));
        return 16'($urandom);
    endfunction

    // Drive one due response, or garbage with ready low
    task automatic present_response();
        int pick = -1;
        int n_due = 0;
        foreach (inflight[i]) begin
            if (inflight[i].due <= cyc) begin
                n_due++;
                if (pick < 0 || $urandom_range(0, n_due - 1) == 0) pick = i;
            end
        end
        if (pick >= 0) begin
            imem_ready     = 1'b1;
            imem_raddr_out = inflight[pick].addr;
            imem_data_out  = mem_word(inflight[pick].addr);
            inflight.delete(pick);
        end else begin
            imem_ready     = 1'b0;
            imem_raddr_out = 16'($urandom);
            imem_data_out  = 16'($urandom);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs on the falling
    // edge, then advance to just after the next rising edge
    task automatic do_cycle();
        bit          exp_push;
        bit          exp_re;
        logic [15:0] w;
        ib_full = force_full || (int'($urandom_range(0, 99)) < p_full);
        if (force_br || (int'($urandom_range(0, 99)) < p_br)) begin
            branch_taken  = 1'b1;
            branch_target = force_br ? force_tgt : pick_target();
        end else begin
            branch_taken  = 1'b0;
            branch_target = 16'($urandom);
        end
        present_response();

        @(negedge clk);
        if (!rst_n) begin
            ref_expect = RESET_PC;
            ref_halted = 1'b0;
        end
        exp_re   = rst_n && !ib_full && !ref_halted;
        exp_push = rst_n && imem_ready && (imem_raddr_out == ref_expect) && !ib_full && !branch_taken;
        check("imem_re", {31'd0, imem_re}, {31'd0, exp_re});
        check("ib_push", {31'd0, ib_push}, {31'd0, exp_push});
        if (ib_push) begin
            check("push_addr", {16'd0, ib_push_data[31:16]}, {16'd0, ref_expect});
            check("push_data", {16'd0, ib_push_data[15:0]}, {16'd0, mem_word(ib_push_data[31:16])});
        end
        if (exp_push) begin
            n_push++;
            w = mem_word(ref_expect);
`ifdef FETCH_HALT_EN
            if (w[15:12] == 4'hF) ref_halted = 1'b1;
`endif
            ref_expect = ref_expect + 16'd1;
        end
        if (rst_n && branch_taken) begin
            ref_expect = branch_target;
            ref_halted = 1'b0;
        end
        last_push  = ib_push;
        last_re    = imem_re;
        last_raddr = imem_raddr;
        last_addr  = ib_push_data[31:16];
        last_data  = ib_push_data[15:0];
        if (imem_re) inflight.push_back('{imem_raddr, cyc + int'($urandom_range(lat_min, lat_max))});

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        force_full = 1'b0;
        force_br   = 1'b0;
        p_full     = 0;
        p_br       = 0;
        inflight.delete();
        repeat (2) do_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bit          found;
        logic [15:0] got_addr[3];
        int          n_got;
        int          start_push;

        rst_n          = 1'b0;
        ib_full        = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 16'h0000;
        imem_ready     = 1'b0;
        imem_raddr_out = 16'h1234;
        imem_data_out  = 16'h0000;
        ref_expect     = RESET_PC;
        ref_halted     = 1'b0;

        // Reset values
        @(posedge clk);
        #1;
        check("rst_re", {31'd0, imem_re}, 32'd0);
        check("rst_push", {31'd0, ib_push}, 32'd0);
        check("rst_raddr", {16'd0, imem_raddr}, {16'd0, RESET_PC});

        // Streaming with a 1-cycle memory and the IB never full
        lat_min = 1; lat_max = 1;
        apply_reset();
        do_cycle();
        check("first_re", {31'd0, last_re}, 32'd1);
        check("first_raddr", {16'd0, last_raddr}, {16'd0, RESET_PC});
        check("first_no_push", {31'd0, last_push}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            do_cycle();
            check("stream_push", {31'd0, last_push}, 32'd1);
            check("stream_addr", {16'd0, last_addr}, {16'd0, RESET_PC + 16'(k - 1)});
            check("stream_raddr", {16'd0, last_raddr}, {16'd0, RESET_PC + 16'(k)});
        end

        // Drop: the response for address 5 arrives while the IB is full
        apply_reset();
        repeat (6) do_cycle();
        check("pre_drop_addr", {16'd0, last_addr}, 32'd4);
        force_full = 1'b1;
        do_cycle();
        check("drop_no_push", {31'd0, last_push}, 32'd0);
        do_cycle();
        check("rewind_raddr", {16'd0, last_raddr}, 32'd5);
        check("full_no_re", {31'd0, last_re}, 32'd0);
        do_cycle();
        force_full = 1'b0;
        do_cycle();
        check("replay_re", {31'd0, last_re}, 32'd1);
        check("replay_raddr", {16'd0, last_raddr}, 32'd5);
        do_cycle();
        check("replay_push", {31'd0, last_push}, 32'd1);
        check("replay_addr", {16'd0, last_addr}, 32'd5);
        do_cycle();
        check("after_replay", {16'd0, last_addr}, 32'd6);

        // Redirect to 0x0040 with four requests in flight
        apply_reset();
        lat_min = 4; lat_max = 4;
        repeat (10) do_cycle();
        check("inflight_cnt", 32'(inflight.size()), 32'd4);
        force_br = 1'b1; force_tgt = 16'h0040;
        do_cycle();
        force_br = 1'b0;
        check("br_no_push", {31'd0, last_push}, 32'd0);
        do_cycle();
        check("br_raddr", {16'd0, last_raddr}, 32'h0040);
        check("br_re", {31'd0, last_re}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            do_cycle();
            if (last_push) found = 1'b1;
        end
        check("br_push_seen", {31'd0, found}, 32'd1);
        check("br_first_addr", {16'd0, last_addr}, 32'h0040);
        check("br_first_data", {16'd0, last_data}, {16'd0, mem_word(16'h0040)});

        // Address wrap from 0xFFFE
        apply_reset();
        lat_min = 1; lat_max = 1;
        force_br = 1'b1; force_tgt = 16'hFFFE;
        do_cycle();
        force_br = 1'b0;
        n_got = 0;
        for (int i = 0; i < 20 && n_got < 3; i++) begin
            do_cycle();
            if (last_push) begin
                got_addr[n_got] = last_addr;
                n_got++;
            end
        end
        check("wrap_count", 32'(n_got), 32'd3);
        check("wrap_a0", {16'd0, got_addr[0]}, 32'hFFFE);
        check("wrap_a1", {16'd0, got_addr[1]}, 32'hFFFF);
        check("wrap_a2", {16'd0, got_addr[2]}, 32'h0000);

`ifdef FETCH_HALT_EN
        // Halt word at address 3, then resume with a branch to 0
        apply_reset();
        halt_word_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            do_cycle();
            if (last_push && last_addr == 16'h0003) found = 1'b1;
        end
        check("halt_push_seen", {31'd0, found}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_cycle();
            check("halt_re", {31'd0, last_re}, 32'd0);
        end
        halt_word_en = 1'b0;
        force_br = 1'b1; force_tgt = 16'h0000;
        do_cycle();
        force_br = 1'b0;
        do_cycle();
        check("resume_re", {31'd0, last_re}, 32'd1);
        check("resume_raddr", {16'd0, last_raddr}, 32'h0000);
`endif

        // Asynchronous reset in the middle of the stream
        apply_reset();
        lat_min = 2; lat_max = 3; p_full = 20;
        repeat (15) do_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("async_re", {31'd0, imem_re}, 32'd0);
        check("async_push", {31'd0, ib_push}, 32'd0);
        check("async_raddr", {16'd0, imem_raddr}, {16'd0, RESET_PC});
        p_full = 0;
        repeat (2) do_cycle();
        rst_n = 1'b1;
        do_cycle();
        check("restart_re", {31'd0, last_re}, 32'd1);
        check("restart_raddr", {16'd0, last_raddr}, {16'd0, RESET_PC});
        repeat (20) do_cycle();

        // Random traffic: out-of-order responses, IB back-pressure, branches
        lat_min = 1; lat_max = 5; p_full = 25; p_br = 3;
        start_push = n_push;
        repeat (3000) do_cycle();
        check("progress_ooo", {31'd0, (n_push - start_push) > 100}, 32'd1);

        // Random traffic: fixed latency and heavy back-pressure
        lat_min = 3; lat_max = 3; p_full = 40; p_br = 2;
        start_push = n_push;
        repeat (2000) do_cycle();
        check("progress_fixed", {31'd0, (n_push - start_push) > 50}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time bound for the whole run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
